// File: rtl/kp_pkg.sv
// Shared types and the row/column-to-hex code table for the keypad scanner.
//   kp_state_e   : debounce FSM state encoding (2 bits)
//   frame_res_e  : result of one full four-column scan frame
//   frame_acc_t  : running frame result plus the code of the single key seen so far
//   key_lookup() : maps a (row, column) intersection to its hex key code
package kp_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned CODE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_res_e;

  typedef struct packed {
    frame_res_e        res;
    logic [CODE_W-1:0] code;
  } frame_acc_t;

  // Keypad legend, rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [CODE_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [CODE_W-1:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner.
//   row_in    : keypad rows, active low, asynchronous
//   col_out   : column drive, active low, one-hot-low
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle strobe on acceptance
//   key_held  : accepted key still down
// slave modport is the scanner; master modport is the keypad/consumer side.
interface keypad_scanner_if;

  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

endinterface

// File: rtl/kp_col_scan.sv
// Column scanner: row synchronizer, dwell counter and active-low column rotation.
//   clk, rst   : clock, synchronous active-low reset
//   row_in     : raw keypad rows (asynchronous)
//   col_out    : registered column drive, exactly one bit low
//   sample_c   : high on the last dwell cycle of the current column
//   col_idx    : index of the column currently driven low
//   rows_sync  : rows after the 2-FF synchronizer
module kp_col_scan #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       sample_c,
  output logic [1:0] col_idx,
  output logic [3:0] rows_sync
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchronizer; idle rows read as all-high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  // Dwell counter and column rotation; scanning free-runs regardless of key state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      col_out <= 4'b1110;
      col_idx <= 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      col_out <= {col_out[2:0], col_out[3]};
      col_idx <= col_idx + 2'd1;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign sample_c  = (cnt_q == CNT_LAST);
  assign rows_sync = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: frame accumulation over the four column samples
// and a press/release debounce FSM producing a single strobe per key press.
//   clk, rst : clock, synchronous active-low reset
//   bus      : keypad_scanner_if.slave (row_in in; col_out, key_code,
//              key_valid, key_held out)
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 5,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scanner_if.slave    bus
);

  localparam int unsigned    FC_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [FC_W-1:0] FC_DONE = FC_W'(DEBOUNCE_FRAMES);

  logic [3:0] col_out_w;
  logic       sample_c;
  logic [1:0] col_idx;
  logic [3:0] rows_sync;

  kp_col_scan #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (bus.row_in),
    .col_out   (col_out_w),
    .sample_c  (sample_c),
    .col_idx   (col_idx),
    .rows_sync (rows_sync)
  );

  // ---------------- frame accumulation ----------------
  frame_acc_t  acc_q;
  frame_acc_t  merged;
  logic [2:0]  col_hits;
  logic [1:0]  col_row;
  logic        frame_end;

  // Fold the current column's low rows into the running frame result.
  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < int'(KP_ROWS); r++) begin
      if (!rows_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    merged = acc_q;
    case (acc_q.res)
      FR_NONE: begin
        if (col_hits == 3'd1) begin
          merged.res  = FR_SINGLE;
          merged.code = key_lookup(col_row, col_idx);
        end else if (col_hits != 3'd0) begin
          merged.res  = FR_MULTI;
        end
      end
      FR_SINGLE: begin
        if (col_hits != 3'd0) merged.res = FR_MULTI;
      end
      default: merged.res = FR_MULTI;
    endcase
    frame_end = sample_c && (col_idx == 2'd3);
  end

  // Accumulator restarts after the col3 sample, whose result goes straight to the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '{res: FR_NONE, code: 4'h0};
    end else if (frame_end) begin
      acc_q <= '{res: FR_NONE, code: 4'h0};
    end else if (sample_c) begin
      acc_q <= merged;
    end
  end

  // ---------------- debounce FSM ----------------
  kp_state_e         state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [FC_W-1:0]   fcnt_inc;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              accept;
  logic              released;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      fcnt_q      <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      fcnt_q      <= fcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Evaluated only at frame end; accept/release completion applied after the case.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    fcnt_d      = fcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    released    = 1'b0;
    fcnt_inc    = fcnt_q + FC_ONE;

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (merged.res == FR_SINGLE) begin
            cand_d  = merged.code;
            fcnt_d  = FC_ONE;
            state_d = ST_DEBOUNCE;
            accept  = (FC_ONE == FC_DONE);
          end
        end
        ST_DEBOUNCE: begin
          if (merged.res == FR_SINGLE) begin
            if (merged.code == cand_q) begin
              fcnt_d = fcnt_inc;
              accept = (fcnt_inc == FC_DONE);
            end else begin
              cand_d = merged.code;
              fcnt_d = FC_ONE;
              accept = (FC_ONE == FC_DONE);
            end
          end else begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (merged.res == FR_NONE) begin
            fcnt_d   = FC_ONE;
            state_d  = ST_RELEASE;
            released = (FC_ONE == FC_DONE);
          end
        end
        ST_RELEASE: begin
          if (merged.res == FR_NONE) begin
            fcnt_d   = fcnt_inc;
            released = (fcnt_inc == FC_DONE);
          end else begin
            state_d  = ST_PRESSED;
          end
        end
      endcase
    end

    if (accept) begin
      key_code_d  = cand_d;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      state_d     = ST_PRESSED;
    end
    if (released) begin
      key_held_d  = 1'b0;
      state_d     = ST_IDLE;
      fcnt_d      = '0;
    end
  end

  assign bus.col_out   = col_out_w;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with DWELL_CYCLES=8, DEBOUNCE_FRAMES=3
// (32-cycle frames). A keypad model pulls a row low whenever a pressed key's
// column is driven low. cyc counts posedges since reset release, so frame n
// ends on the cycle cyc == 32n+31 and an acceptance strobe is seen at 32n+32.
module tb_keypad_scanner;

  logic clk;
  logic rst;
  logic [15:0] pressed;
  int cyc;
  int n_cmp;
  int n_bad;
  int pulse_cnt;
  int last_pulse_cyc;
  logic [3:0] last_pulse_code;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .DWELL_CYCLES    (8),
    .DEBOUNCE_FRAMES (3),
    .CNT_W           (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: key (r,c) is at bit r*4+c of pressed.
  always_comb begin
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.col_out[c]) rows[r] = 1'b0;
      end
    end
    kif.row_in = rows;
  end

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kif.key_valid) begin
      pulse_cnt       = pulse_cnt + 1;
      last_pulse_cyc  = cyc;
      last_pulse_code = kif.key_code;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    n_cmp++;
    if (cyc !== target) begin
      n_bad++;
      $display("FAIL wait_cyc: got cyc %0d required %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    pressed = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (kif.col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col_out: got %b required 1110", kif.col_out); end
    n_cmp++; if (kif.key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code: got %h required 0", kif.key_code); end
    n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b required 0", kif.key_valid); end
    n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %b required 0", kif.key_held); end
    rst = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    int base;
    pressed = 16'h0;
    do_reset();
    base = pulse_cnt;
    for (int k = 1; k <= 80; k++) begin
      wait_cyc(k);
      exp_col = 4'b0001 << ((k / 8) % 4);
      exp_col = ~exp_col;
      n_cmp++;
      if (kif.col_out !== exp_col) begin
        n_bad++;
        $display("FAIL idle_col_out: cyc %0d got %b required %b", k, kif.col_out, exp_col);
      end
      n_cmp++;
      if (kif.key_held !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_key_held: cyc %0d got %b required 0", k, kif.key_held);
      end
    end
    n_cmp++;
    if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL idle_no_pulse: got %0d pulses required 0", pulse_cnt - base); end
  endtask

  task automatic test_single_key();
    int base;
    pressed = 16'h0;
    pressed[6] = 1'b1;
    do_reset();
    base = pulse_cnt;
    wait_cyc(95);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL key6_early: got %0d pulses required 0", pulse_cnt - base); end
    wait_cyc(96);
    n_cmp++; if (kif.key_valid !== 1'b1) begin n_bad++; $display("FAIL key6_valid: got %b required 1", kif.key_valid); end
    n_cmp++; if (kif.key_code !== 4'h6) begin n_bad++; $display("FAIL key6_code: got %h required 6", kif.key_code); end
    wait_cyc(97);
    n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL key6_strobe_len: got %b required 0", kif.key_valid); end
    n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL key6_held: got %b required 1", kif.key_held); end
    wait_cyc(97 + 3200);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL key6_hold_pulses: got %0d required 1", pulse_cnt - base); end
    n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL key6_hold_held: got %b required 1", kif.key_held); end
  endtask

  task automatic test_bounce();
    int base;
    pressed = 16'h0;
    do_reset();
    base = pulse_cnt;
    for (int i = 0; i < 64; i++) begin
      pressed[13] = ((i / 5) % 2 == 0);
      @(negedge clk);
    end
    pressed[13] = 1'b1;
    wait_cyc(159);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL bounce_early: got %0d pulses required 0", pulse_cnt - base); end
    wait_cyc(170);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d required 1", pulse_cnt - base); end
    n_cmp++; if (last_pulse_cyc !== 160) begin n_bad++; $display("FAIL bounce_pulse_cyc: got %0d required 160", last_pulse_cyc); end
    n_cmp++; if (last_pulse_code !== 4'h0) begin n_bad++; $display("FAIL bounce_code: got %h required 0", last_pulse_code); end

    // two-frame press only
    pressed = 16'h0;
    pressed[13] = 1'b1;
    do_reset();
    base = pulse_cnt;
    wait_cyc(64);
    pressed[13] = 1'b0;
    wait_cyc(200);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL short_press_pulses: got %0d required 0", pulse_cnt - base); end
    n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL short_press_held: got %b required 0", kif.key_held); end
  endtask

  task automatic test_multi_key();
    int base;
    pressed = 16'h0;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    do_reset();
    base = pulse_cnt;
    wait_cyc(160);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL multi_pulses: got %0d required 0", pulse_cnt - base); end
    pressed[5] = 1'b0;
    wait_cyc(270);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL multi_rollback_pulses: got %0d required 1", pulse_cnt - base); end
    n_cmp++; if (last_pulse_cyc !== 256) begin n_bad++; $display("FAIL multi_pulse_cyc: got %0d required 256", last_pulse_cyc); end
    n_cmp++; if (last_pulse_code !== 4'h1) begin n_bad++; $display("FAIL multi_code: got %h required 1", last_pulse_code); end
  endtask

  task automatic test_release();
    int  base;
    logic dropped;
    pressed = 16'h0;
    pressed[7] = 1'b1;
    do_reset();
    base = pulse_cnt;
    wait_cyc(96);
    n_cmp++; if (kif.key_code !== 4'hB) begin n_bad++; $display("FAIL rel_code: got %h required b", kif.key_code); end
    pressed[7] = 1'b0;
    wait_cyc(191);
    n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL rel_held_before: got %b required 1", kif.key_held); end
    wait_cyc(192);
    n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL rel_held_after: got %b required 0", kif.key_held); end
    n_cmp++; if (kif.key_code !== 4'hB) begin n_bad++; $display("FAIL rel_code_kept: got %h required b", kif.key_code); end

    // re-press after one empty frame
    pressed[7] = 1'b1;
    do_reset();
    base = pulse_cnt;
    wait_cyc(96);
    pressed[7] = 1'b0;
    wait_cyc(128);
    pressed[7] = 1'b1;
    dropped = 1'b0;
    for (int k = 129; k <= 300; k++) begin
      wait_cyc(k);
      if (kif.key_held !== 1'b1) dropped = 1'b1;
    end
    n_cmp++; if (dropped !== 1'b0) begin n_bad++; $display("FAIL repress_held: got drop %b required 0", dropped); end
    n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL repress_pulses: got %0d required 1", pulse_cnt - base); end
  endtask

  task automatic test_reset_mid_press();
    int base;
    pressed = 16'h0;
    pressed[6] = 1'b1;
    do_reset();
    wait_cyc(150);
    n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL mid_pre_held: got %b required 1", kif.key_held); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (kif.col_out !== 4'b1110) begin n_bad++; $display("FAIL mid_col_out: got %b required 1110", kif.col_out); end
    n_cmp++; if (kif.key_code !== 4'h0) begin n_bad++; $display("FAIL mid_key_code: got %h required 0", kif.key_code); end
    n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL mid_key_valid: got %b required 0", kif.key_valid); end
    n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL mid_key_held: got %b required 0", kif.key_held); end
    rst = 1'b1;
    base = pulse_cnt;
    wait_cyc(95);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL mid_early: got %0d pulses required 0", pulse_cnt - base); end
    wait_cyc(96);
    n_cmp++; if (kif.key_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid: got %b required 1", kif.key_valid); end
    n_cmp++; if (kif.key_code !== 4'h6) begin n_bad++; $display("FAIL mid_code: got %h required 6", kif.key_code); end
  endtask

  initial begin
    rst             = 1'b0;
    pressed         = 16'h0;
    n_cmp           = 0;
    n_bad           = 0;
    pulse_cnt       = 0;
    last_pulse_cyc  = -1;
    last_pulse_code = 4'h0;
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_release();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one active-low column at a time and reading the four active-low rows.
- Synchronizes and debounces the rows, rejects multi-key presses, and emits a one-cycle strobe with a 4-bit hex key code.
- It is the input-side counterpart of the multiplexed 7-segment display driver.
- key_code maps directly onto the low bits of the display's {dp,char[4:0]} character format.

Parameters:
- DWELL_CYCLES, 50000, clock cycles each column is held low (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 5, consecutive identical full-scan frames needed to accept a press or a release.
- CNT_W, 16, width of the dwell counter; must satisfy 2^CNT_W >= DWELL_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active low
- row_in  input  4  keypad rows, active low, externally pulled up, asynchronous
- col_out  output  4  column drive, active low, exactly one bit low at all times
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle strobe when a new key is accepted
- key_held  output  1  high while an accepted key remains pressed (before release debounce completes)

Behaviour:
- Reset is synchronous: all state is sampled on the posedge of clk while rst=0.
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, synchronizer=4'b1111, counters=0, FSM=IDLE.
- Synchronizer: row_in passes through a 2-FF synchronizer (2-cycle latency).
- Dwell counter: counts 0..DWELL_CYCLES-1 and wraps.
- Column sampling: on the cycle cnt==DWELL_CYCLES-1, the synchronized rows are sampled for the current column. col_out then rotates on the next edge: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Frame: four column samples (col0..col3). Frame end is the col3 sample cycle.
- Frame result is one of:
  - NONE: no low row seen.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low, in any arrangement.
- Code map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. It evaluates only at frame end; frame_cnt counts consecutive qualifying frames.
- IDLE:
  - SINGLE(k) -> DEBOUNCE; cand=k, frame_cnt=1.
  - NONE or MULTI -> stay.
- DEBOUNCE:
  - SINGLE(cand) -> frame_cnt+1.
  - SINGLE(other) -> cand=other, frame_cnt=1.
  - NONE or MULTI -> IDLE.
  - When frame_cnt reaches DEBOUNCE_FRAMES: key_code<=cand, key_valid=1 for the next cycle only, key_held<=1, -> PRESSED. With DEBOUNCE_FRAMES=1, acceptance occurs at the first frame end.
- PRESSED:
  - NONE -> RELEASE; frame_cnt=1.
  - SINGLE(any) or MULTI -> stay. No new strobe; rollover is suppressed.
- RELEASE:
  - NONE -> frame_cnt+1. When it reaches DEBOUNCE_FRAMES: key_held<=0, -> IDLE.
  - Any non-NONE -> PRESSED.
- Latency: key_valid rises 1 cycle after the frame-end sample of the DEBOUNCE_FRAMES-th qualifying frame.
- key_code holds its value until the next acceptance; it is not cleared on release.
- Held key: exactly one key_valid per press, regardless of hold duration.
- Reset mid-operation: immediate return to reset values. A key still pressed must re-debounce from IDLE, starting with the first full frame after reset.
- Scan behaviour is independent of FSM state: scanning never stalls.

Decomposition:
- Shared package kp_pkg:
  - FSM state encoding (2 bits).
  - Frame-result encoding (NONE/SINGLE/MULTI).
  - 16-entry row/column-to-hex code table.
- One natural sub-module: kp_col_scan. It contains the synchronizer, dwell counter and column rotation, and outputs col_out, sample strobe, column index and synced rows.
- The top module holds frame accumulation and the debounce FSM.

Test Plan (DWELL_CYCLES=8, DEBOUNCE_FRAMES=3, frame=32 cycles):
- Reset then idle rows=4'hF -> col_out=1110 and then 1101/1011/0111 each exactly 8 cycles, wrapping to 1110; key_valid never asserts; key_held=0.
- Row1 held low only while col_out=1011 (key 6), stable from frame 0 -> single key_valid pulse at the end of the 3rd frame with key_code=4'h6; key_held=1. Holding for 100 frames produces no further pulse.
- Key 0 (r3,c1) toggled every 5 cycles for 2 frames, then stable -> no pulse during bounce; exactly one pulse with code 4'h0 after 3 stable frames. A 2-frame press alone -> no pulse.
- Keys 1 and 5 pressed together -> no key_valid. After releasing key 5, with 1 still held -> one pulse, code 4'h1.
- Release of accepted key B -> key_held stays 1 for 2 empty frames and drops after the 3rd. A re-press after 1 empty frame keeps key_held=1 with no new pulse.
- rst=0 for 1 cycle mid-PRESSED with key still down -> outputs return to reset values; a new pulse with the same code arrives 3 full frames later.
